// File: rtl/mor1kx_dpram_arbiter.sv
// Two-requester arbiter sharing RAM port A, with round-robin fairness, lock ownership
// and write-collision stalls against port B. Optional stall counter: MOR1KX_DPRAM_ARBITER_STATS_EN.
module mor1kx_dpram_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic                  lock0,
    input  logic                  lock1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] din1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic                  ram_we_a,
    output logic [DATA_WIDTH-1:0] ram_din_a,
    input  logic [DATA_WIDTH-1:0] ram_dout_a,
    input  logic                  ram_we_b,
    input  logic [ADDR_WIDTH-1:0] ram_addr_b,
    output logic [15:0]           stall_cnt,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t                  state;
    logic                    prio1;
    logic                    elig0;
    logic                    elig1;
    logic                    pick_valid;
    logic                    pick1;
    logic                    win_we;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic                    collide;
    logic                    grant;

    // Handshake: a requester holds reqN (with we/addr/din stable) until gntN is
    // seen high in the same cycle; gntN high means the access is taken at this edge.
    always_comb begin
        elig0      = req0 && (state != OWN1);
        elig1      = req1 && (state != OWN0);
        pick_valid = elig0 || elig1;
        pick1      = elig1 && (!elig0 || prio1);
        win_we     = pick1 ? we1 : we0;
        win_addr   = pick1 ? addr1 : addr0;
        collide    = pick_valid && win_we && ram_we_b && (ram_addr_b == win_addr);
        grant      = pick_valid && !collide && rst_n;
    end

    assign gnt0       = grant && !pick1;
    assign gnt1       = grant && pick1;
    assign ram_addr_a = win_addr;
    assign ram_we_a   = grant && win_we;
    assign ram_din_a  = pick1 ? din1 : din0;
    assign rdata      = ram_dout_a;
    assign state_dbg  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ARB;
            prio1   <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= gnt0 && !we0;
            rvalid1 <= gnt1 && !we1;
            // A stalled write freezes arbitration so the retry sees the same ordering.
            if (!collide) begin
                if (grant) begin
                    prio1 <= !pick1;
                end
                case (state)
                    ARB: begin
                        if (gnt0 && lock0) begin
                            state <= OWN0;
                        end else if (gnt1 && lock1) begin
                            state <= OWN1;
                        end
                    end
                    OWN0: begin
                        if (!lock0) begin
                            state <= ARB;
                        end
                    end
                    OWN1: begin
                        if (!lock1) begin
                            state <= ARB;
                        end
                    end
                    default: state <= ARB;
                endcase
            end
        end
    end

`ifdef MOR1KX_DPRAM_ARBITER_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 16'h0000;
        end else if (collide && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'h0001;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mor1kx_dpram_arbiter.sv
// Self-checking bench for mor1kx_dpram_arbiter: reset checks, single-cycle vector table,
// directed multi-cycle sequences, then randomized traffic against a reference model.
module tb_mor1kx_dpram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  r_req = 2'b00;
    logic [1:0]  r_we = 2'b00;
    logic [1:0]  r_lock = 2'b00;
    logic [7:0]  r_addr [2];
    logic [31:0] r_din [2];
    logic        r_we_b = 1'b0;
    logic [7:0]  r_addr_b = 8'h00;

    logic        gnt0, gnt1, rvalid0, rvalid1, ram_we_a;
    logic [31:0] rdata, ram_din_a;
    logic [7:0]  ram_addr_a;
    logic [31:0] ram_dout_a;
    logic [15:0] stall_cnt;
    logic [1:0]  state_dbg;

    int n_tests = 0;
    int n_fail = 0;

    logic [31:0] mem [256];
    bit          mem_valid [256];
    logic [31:0] ref_mem [256];
    logic [31:0] exp_q [$];

    mor1kx_dpram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(r_req[0]), .req1(r_req[1]),
        .we0(r_we[0]), .we1(r_we[1]),
        .lock0(r_lock[0]), .lock1(r_lock[1]),
        .addr0(r_addr[0]), .addr1(r_addr[1]),
        .din0(r_din[0]), .din1(r_din[1]),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata),
        .ram_addr_a(ram_addr_a), .ram_we_a(ram_we_a), .ram_din_a(ram_din_a),
        .ram_dout_a(ram_dout_a),
        .ram_we_b(r_we_b), .ram_addr_b(r_addr_b),
        .stall_cnt(stall_cnt), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] init_val(input logic [7:0] a);
        return (a == 8'h10) ? 32'hCAFE0001 : {8'h5A, a, ~a, 8'h3C};
    endfunction

    // Synchronous RAM port A with registered read data.
    always @(posedge clk) begin
        if (ram_we_a) begin
            mem[ram_addr_a]       <= ram_din_a;
            mem_valid[ram_addr_a] <= 1'b1;
        end
        ram_dout_a <= mem_valid[ram_addr_a] ? mem[ram_addr_a] : init_val(ram_addr_a);
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle();
        r_req = 2'b00; r_we = 2'b00; r_lock = 2'b00;
        r_addr[0] = 8'h00; r_addr[1] = 8'h00;
        r_din[0] = 32'h0; r_din[1] = 32'h0;
        r_we_b = 1'b0; r_addr_b = 8'h00;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic drive(input int k, input logic req, input logic we, input logic lock,
                         input logic [7:0] addr, input logic [31:0] din);
        r_req[k] = req; r_we[k] = we; r_lock[k] = lock; r_addr[k] = addr; r_din[k] = din;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       r0, r1, w0, w1;
        logic [7:0] a0, a1;
        logic       wb;
        logic [7:0] ab;
        logic       g0, g1, wea;
    } vec_t;

    vec_t vecs [10];

    // ---------------- reference model state ----------------
    int          owner;
    int          last;
    bit          exp_rv [2];
    int unsigned stall_model;

    int  model_w;
    bit  model_stall;

    task automatic model_pick();
        bit c0, c1;
        c0 = r_req[0] && (owner == -1 || owner == 0);
        c1 = r_req[1] && (owner == -1 || owner == 1);
        if (c0 && c1)      model_w = (last == 0) ? 1 : 0;
        else if (c0)       model_w = 0;
        else if (c1)       model_w = 1;
        else               model_w = -1;
        model_stall = 1'b0;
        if (model_w >= 0 && r_we[model_w] && r_we_b && r_addr_b == r_addr[model_w]) begin
            model_stall = 1'b1;
            model_w = -1;
        end
    endtask

    task automatic model_commit();
        exp_rv[0] = (model_w == 0) && !r_we[0];
        exp_rv[1] = (model_w == 1) && !r_we[1];
        if (model_w >= 0) begin
            if (r_we[model_w]) ref_mem[r_addr[model_w]] = r_din[model_w];
            else               exp_q.push_back(ref_mem[r_addr[model_w]]);
        end
        if (model_stall) begin
            if (stall_model < 16'hFFFF) stall_model++;
        end else begin
            if (model_w >= 0) last = model_w;
            if (owner == -1) begin
                if (model_w >= 0 && r_lock[model_w]) owner = model_w;
            end else if (!r_lock[owner]) begin
                owner = -1;
            end
        end
    endtask

    function automatic logic [15:0] exp_stall(input int unsigned n);
`ifdef MOR1KX_DPRAM_ARBITER_STATS_EN
        return n[15:0];
`else
        return (n == 0) ? 16'h0000 : 16'h0000;
`endif
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        logic [15:0] stall_exp2;
        logic [31:0] got;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i[7:0]);
        idle();

        // Reset holds grants and RAM write off even with requests present.
        rst_n = 1'b0;
        r_req = 2'b11; r_we = 2'b11;
        settle();
        check("reset_gnt0", {31'b0, gnt0}, 32'd0);
        check("reset_gnt1", {31'b0, gnt1}, 32'd0);
        check("reset_we_a", {31'b0, ram_we_a}, 32'd0);
        check("reset_rvalid", {30'b0, rvalid1, rvalid0}, 32'd0);
        check("reset_stall", {16'b0, stall_cnt}, 32'd0);
        check("reset_state", {30'b0, state_dbg}, 32'd0);
        do_reset();

        vecs[0] = '{1, 0, 0, 0, 8'h10, 8'h00, 0, 8'h00, 1, 0, 0};
        vecs[1] = '{0, 1, 0, 0, 8'h00, 8'h11, 0, 8'h00, 0, 1, 0};
        vecs[2] = '{1, 1, 0, 0, 8'h10, 8'h11, 0, 8'h00, 1, 0, 0};
        vecs[3] = '{0, 0, 1, 1, 8'h10, 8'h11, 1, 8'h10, 0, 0, 0};
        vecs[4] = '{0, 1, 0, 1, 8'h00, 8'h22, 1, 8'h22, 0, 0, 0};
        vecs[5] = '{0, 1, 0, 1, 8'h00, 8'h22, 1, 8'h23, 0, 1, 1};
        vecs[6] = '{1, 0, 0, 0, 8'h05, 8'h00, 1, 8'h05, 1, 0, 0};
        vecs[7] = '{1, 1, 1, 0, 8'h30, 8'h31, 1, 8'h30, 0, 0, 0};
        vecs[8] = '{1, 0, 1, 0, 8'h40, 8'h00, 0, 8'h00, 1, 0, 1};
        vecs[9] = '{1, 1, 0, 1, 8'h50, 8'h51, 0, 8'h00, 1, 0, 0};
        for (int i = 0; i < 10; i++) begin
            do_reset();
            drive(0, vecs[i].r0, vecs[i].w0, 1'b0, vecs[i].a0, 32'h0000_1234);
            drive(1, vecs[i].r1, vecs[i].w1, 1'b0, vecs[i].a1, 32'h0000_5678);
            r_we_b = vecs[i].wb; r_addr_b = vecs[i].ab;
            settle();
            check($sformatf("vec%0d_gnt0", i), {31'b0, gnt0}, {31'b0, vecs[i].g0});
            check($sformatf("vec%0d_gnt1", i), {31'b0, gnt1}, {31'b0, vecs[i].g1});
            check($sformatf("vec%0d_we_a", i), {31'b0, ram_we_a}, {31'b0, vecs[i].wea});
        end

        // Single read: grant now, data one cycle later.
        do_reset();
        drive(0, 1, 0, 0, 8'h10, 32'h0);
        settle();
        check("rd_gnt0", {31'b0, gnt0}, 32'd1);
        check("rd_addr_a", {24'b0, ram_addr_a}, 32'h10);
        step();
        idle();
        settle();
        check("rd_rvalid0", {31'b0, rvalid0}, 32'd1);
        check("rd_rvalid1", {31'b0, rvalid1}, 32'd0);
        check("rd_rdata", rdata, 32'hCAFE0001);

        // Both reading, no lock: grants alternate starting with 0.
        do_reset();
        drive(0, 1, 0, 0, 8'h01, 32'h0);
        drive(1, 1, 0, 0, 8'h02, 32'h0);
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("rr%0d_gnt0", i), {31'b0, gnt0}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("rr%0d_gnt1", i), {31'b0, gnt1}, (i % 2 == 0) ? 32'd0 : 32'd1);
            step();
        end

        // Lock: requester 0 keeps ownership for 3 cycles, 1 waits.
        do_reset();
        drive(0, 1, 0, 1, 8'h03, 32'h0);
        drive(1, 1, 0, 0, 8'h04, 32'h0);
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("lock%0d_gnt0", i), {31'b0, gnt0}, 32'd1);
            check($sformatf("lock%0d_gnt1", i), {31'b0, gnt1}, 32'd0);
            step();
        end
        check("lock_state_own0", {30'b0, state_dbg}, 32'd1);
        drive(0, 0, 0, 0, 8'h03, 32'h0);
        settle();
        check("unlock_gnt1_blocked", {31'b0, gnt1}, 32'd0);
        step();
        settle();
        check("unlock_gnt1", {31'b0, gnt1}, 32'd1);
        step();

        // Collision: write held off for 2 cycles by port B, then lands.
        do_reset();
        drive(1, 1, 1, 0, 8'h22, 32'hDEADBEEF);
        r_we_b = 1'b1; r_addr_b = 8'h22;
        for (int i = 0; i < 2; i++) begin
            settle();
            check($sformatf("coll%0d_gnt1", i), {31'b0, gnt1}, 32'd0);
            check($sformatf("coll%0d_we_a", i), {31'b0, ram_we_a}, 32'd0);
            step();
        end
        r_we_b = 1'b0;
        settle();
        check("coll_gnt1", {31'b0, gnt1}, 32'd1);
        check("coll_we_a", {31'b0, ram_we_a}, 32'd1);
        check("coll_addr_a", {24'b0, ram_addr_a}, 32'h22);
        check("coll_din_a", ram_din_a, 32'hDEADBEEF);
        step();
        ref_mem[8'h22] = 32'hDEADBEEF;
        idle();
        settle();
        stall_exp2 = exp_stall(2);
        check("coll_stall_cnt", {16'b0, stall_cnt}, {16'b0, stall_exp2});
        check("coll_no_rvalid", {30'b0, rvalid1, rvalid0}, 32'd0);
        step();
        drive(0, 1, 0, 0, 8'h22, 32'h0);
        settle();
        check("readback_gnt0", {31'b0, gnt0}, 32'd1);
        step();
        idle();
        settle();
        check("readback_rvalid0", {31'b0, rvalid0}, 32'd1);
        check("readback_rdata", rdata, 32'hDEADBEEF);

        // Reset during a locked read: pending rvalid dropped, ownership cleared.
        do_reset();
        drive(0, 1, 0, 1, 8'h10, 32'h0);
        drive(1, 1, 0, 0, 8'h11, 32'h0);
        settle();
        check("rst_lock_gnt0", {31'b0, gnt0}, 32'd1);
        rst_n = 1'b0;
        idle();
        step();
        check("rst_lock_rvalid0", {31'b0, rvalid0}, 32'd0);
        check("rst_lock_state", {30'b0, state_dbg}, 32'd0);
        check("rst_lock_we_a", {31'b0, ram_we_a}, 32'd0);
        rst_n = 1'b1;
        drive(1, 1, 0, 0, 8'h11, 32'h0);
        settle();
        check("rst_after_gnt1", {31'b0, gnt1}, 32'd1);
        check("rst_after_rvalid0", {31'b0, rvalid0}, 32'd0);
        step();
        idle();
        settle();
        check("rst_after_rvalid1", {31'b0, rvalid1}, 32'd1);
        check("rst_after_rdata", rdata, init_val(8'h11));

        // Randomized traffic against the reference model.
        do_reset();
        owner = -1; last = 1; exp_rv[0] = 0; exp_rv[1] = 0; stall_model = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int k = 0; k < 2; k++) begin
                r_req[k]  = ($urandom_range(0, 3) != 0);
                r_we[k]   = $urandom_range(0, 1) == 1;
                r_lock[k] = ($urandom_range(0, 3) == 0);
                r_addr[k] = 8'hE0 + 8'($urandom_range(0, 7));
                r_din[k]  = $urandom;
            end
            r_we_b   = ($urandom_range(0, 2) == 0);
            r_addr_b = 8'hE0 + 8'($urandom_range(0, 7));
            model_pick();
            settle();
            check("rnd_gnt0", {31'b0, gnt0}, {31'b0, model_w == 0});
            check("rnd_gnt1", {31'b0, gnt1}, {31'b0, model_w == 1});
            check("rnd_we_a", {31'b0, ram_we_a}, {31'b0, model_w >= 0 && r_we[model_w == 1]});
            if (model_w >= 0) check("rnd_addr_a", {24'b0, ram_addr_a}, {24'b0, r_addr[model_w]});
            if (model_w >= 0 && r_we[model_w]) check("rnd_din_a", ram_din_a, r_din[model_w]);
            check("rnd_rvalid0", {31'b0, rvalid0}, {31'b0, exp_rv[0]});
            check("rnd_rvalid1", {31'b0, rvalid1}, {31'b0, exp_rv[1]});
            if ((exp_rv[0] || exp_rv[1]) && exp_q.size() > 0) begin
                got = exp_q.pop_front();
                check("rnd_rdata", rdata, got);
            end
            check("rnd_stall_cnt", {16'b0, stall_cnt}, {16'b0, exp_stall(stall_model)});
            model_commit();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
